// File: rtl/control_pkg.sv
// control_pkg: RV32I opcode constants, writeback/ALU-op encodings and the ctrl_t bundle.
package control_pkg;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;
  typedef struct packed {
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       jalr;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: opcode in, registered control strobes out.
interface control_unit_if;
  logic [6:0] opcode;
  logic       alu_src;
  logic       branch;
  logic       mem_read;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       mem_write;
  logic       jump;
  logic       jalr;
  logic [1:0] alu_op;
  logic       illegal_op;
  modport master (output opcode, input alu_src, branch, mem_read, mem_to_reg, reg_write,
                  mem_write, jump, jalr, alu_op, illegal_op);
  modport slave (input opcode, output alu_src, branch, mem_read, mem_to_reg, reg_write,
                 mem_write, jump, jalr, alu_op, illegal_op);
endinterface

// File: rtl/control_decode.sv
// control_decode: combinational opcode -> ctrl_t; illegal flag only built under CONTROL_ILLEGAL_DETECT_EN.
module control_decode
  import control_pkg::*;
(
  input  logic [6:0] i_opcode,
  output ctrl_t      o_ctrl
);
  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_R;
      end
      OP_IALU: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_I;
      end
      OP_LOAD: begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = WB_MEM;
      end
      OP_STORE: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALUOP_BR;
      end
      OP_JAL: begin
        o_ctrl.jump       = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = WB_PC4;
      end
      OP_JALR: begin
        o_ctrl.jump       = 1'b1;
        o_ctrl.jalr       = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = WB_PC4;
      end
      OP_LUI: begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = WB_IMM;
      end
      default: begin
`ifdef CONTROL_ILLEGAL_DETECT_EN
        o_ctrl.illegal = 1'b1;
`else
        o_ctrl.illegal = 1'b0;
`endif
      end
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: registered RV32I main control decoder, 1-cycle latency.
// Optional illegal-opcode flag enabled by CONTROL_ILLEGAL_DETECT_EN.
module control_unit
  import control_pkg::*;
(
  input logic           clk,
  input logic           reset,
  control_unit_if.slave bus
);
  ctrl_t w_ctrl;
  ctrl_t r_ctrl;
  control_decode u_decode (.i_opcode(bus.opcode), .o_ctrl(w_ctrl));
  always_ff @(posedge clk) r_ctrl <= reset ? '0 : w_ctrl;
  assign bus.alu_src    = r_ctrl.alu_src;
  assign bus.branch     = r_ctrl.branch;
  assign bus.mem_read   = r_ctrl.mem_read;
  assign bus.mem_to_reg = r_ctrl.mem_to_reg;
  assign bus.reg_write  = r_ctrl.reg_write;
  assign bus.mem_write  = r_ctrl.mem_write;
  assign bus.jump       = r_ctrl.jump;
  assign bus.jalr       = r_ctrl.jalr;
  assign bus.alu_op     = r_ctrl.alu_op;
  assign bus.illegal_op = r_ctrl.illegal;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of the registered decoder against hand-built vectors.
module tb_control_unit;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
`ifdef CONTROL_ILLEGAL_DETECT_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif
  // {alu_src, branch, mem_read, mem_to_reg, reg_write, mem_write, jump, jalr, alu_op}
  localparam logic [10:0] E_ZERO  = 11'b0_0_0_00_0_0_0_0_00;
  localparam logic [10:0] E_R     = 11'b0_0_0_00_1_0_0_0_10;
  localparam logic [10:0] E_IALU  = 11'b1_0_0_00_1_0_0_0_11;
  localparam logic [10:0] E_LOAD  = 11'b1_0_1_01_1_0_0_0_00;
  localparam logic [10:0] E_STORE = 11'b1_0_0_00_0_1_0_0_00;
  localparam logic [10:0] E_BR    = 11'b0_1_0_00_0_0_0_0_01;
  localparam logic [10:0] E_JAL   = 11'b0_0_0_10_1_0_1_0_00;
  localparam logic [10:0] E_JALR  = 11'b1_0_0_10_1_0_1_1_00;
  localparam logic [10:0] E_LUI   = 11'b1_0_0_11_1_0_0_0_00;
  control_unit_if bus ();
  control_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [11:0] obs();
    return {bus.alu_src, bus.branch, bus.mem_read, bus.mem_to_reg, bus.reg_write,
            bus.mem_write, bus.jump, bus.jalr, bus.alu_op, bus.illegal_op};
  endfunction
  task automatic check(input string tag, input logic [10:0] e, input logic ill);
    logic [11:0] o;
    o = obs();
    total++;
    assert (o === {e, ill}) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, {e, ill});
    end
    total++;
    assert (!(bus.mem_read && bus.mem_write) && !(bus.branch && bus.jump) &&
            !(bus.jalr && !bus.jump)) else begin
      bad++;
      $error("FAIL %s_invariant observed=%b", tag, o);
    end
  endtask
  task automatic step(input logic [6:0] op, input string tag, input logic [10:0] e,
                      input logic ill);
    bus.opcode = op;
    @(posedge clk);
    #1;
    check(tag, e, ill);
  endtask
  initial begin
    reset = 1'b1;
    bus.opcode = 7'b0110011;
    @(posedge clk); #1; check("reset1", E_ZERO, 1'b0);
    @(posedge clk); #1; check("reset2", E_ZERO, 1'b0);
    reset = 1'b0;
    step(7'b0110011, "rtype", E_R, 1'b0);
    step(7'b0100011, "store", E_STORE, 1'b0);
    step(7'b0010011, "ialu", E_IALU, 1'b0);
    step(7'b0000011, "load", E_LOAD, 1'b0);
    step(7'b1100011, "branch", E_BR, 1'b0);
    step(7'b1101111, "jal", E_JAL, 1'b0);
    step(7'b1100111, "jalr", E_JALR, 1'b0);
    step(7'b0110111, "lui", E_LUI, 1'b0);
    step(7'b1111111, "illegal_ff", E_ZERO, ILL);
    step(7'b0000000, "illegal_00", E_ZERO, ILL);
    step(7'b0110011, "rtype_after_ill", E_R, 1'b0);
    // opcode wiggles between edges must not reach the outputs
    #2 bus.opcode = 7'b0100011;
    #1 check("glitch_hold1", E_R, 1'b0);
    #2 bus.opcode = 7'b0110011;
    #1 check("glitch_hold2", E_R, 1'b0);
    @(posedge clk); #1; check("glitch_edge", E_R, 1'b0);
    bus.opcode = 7'b0100011;
    #2 bus.opcode = 7'b1100111;
    @(posedge clk); #1; check("glitch_last", E_JALR, 1'b0);
    bus.opcode = 7'b0000011;
    reset = 1'b1;
    @(posedge clk); #1; check("midreset", E_ZERO, 1'b0);
    bus.opcode = 7'b1111111;
    @(posedge clk); #1; check("midreset_ill", E_ZERO, 1'b0);
    reset = 1'b0;
    step(7'b0000011, "resume_load", E_LOAD, 1'b0);
    step(7'b0100011, "resume_store", E_STORE, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
